// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder for the MEM-stage load/store port.
// Accepts one read or write at a time and holds it for LATENCY cycles.
// The access commits to the internal word array on entry into the response state.
// The response is then returned under a valid/ready handshake.
//
// Optional feature: define DMEM_ACCESS_CHECK_EN to flag out-of-range or misaligned
// accesses. Flagged accesses set rsp_err, flagged writes are dropped and flagged reads
// return 0. When the macro is undefined, addr[1:0] is ignored, the word index wraps and
// rsp_err is tied to 0.
//
// Parameters:
//   DEPTH_LOG2  log2 of the word count
//   LATENCY     cycles from the accepting cycle to the response cycle (1..15)
//   BASE_ADDR   byte address mapped to word 0
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_addr, req_wdata   request (1 = write), byte address, write data
//   req_be                        write byte enables (ignored on reads)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            read data (0 for writes), access error flag
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Not reset: contents survive reset.
  logic [31:0] mem [Words];

  logic                  accept;
  logic                  commit;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  acc_err;
  logic [31:0]           rd_next;

  assign accept = req_valid && (state_q == StIdle);

  // With LATENCY = 1 the access commits on the accepting edge, so it uses the live request.
  // Otherwise it uses the captured copy. Reset gates the commit so that a pending write
  // is dropped.
  assign commit = !reset &&
                  (((state_q == StWait) && (cnt_q == 4'd0)) || ((LATENCY == 1) && accept));

  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign offset = acc_addr - BASE_ADDR;
  assign idx    = offset[DEPTH_LOG2+1:2];

`ifdef DMEM_ACCESS_CHECK_EN
  localparam logic [32:0] Span = 33'(1) << (DEPTH_LOG2 + 2);
  assign acc_err = ({1'b0, offset} >= Span) || (acc_addr[1:0] != 2'b00);
`else
  logic unused_offset;
  assign unused_offset = ^offset;
  assign acc_err       = 1'b0;
`endif

  assign rd_next = (acc_we || acc_err) ? 32'h0 : mem[idx];

  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 2);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp: begin
          if (rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Response data is held from commit until the next commit.
      if (commit) begin
        rdata_q <= rd_next;
        err_q   <= acc_err;
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int Lat = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Main DUT, LATENCY = 2
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_be = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Second DUT, LATENCY = 1
  logic        d1_req_valid = 1'b0;
  logic        d1_req_ready;
  logic        d1_req_we = 1'b0;
  logic [31:0] d1_req_addr = 32'h0;
  logic [31:0] d1_req_wdata = 32'h0;
  logic [3:0]  d1_req_be = 4'h0;
  logic        d1_rsp_valid;
  logic        d1_rsp_ready = 1'b1;
  logic [31:0] d1_rsp_rdata;
  logic        d1_rsp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(Lat), .BASE_ADDR(32'h0)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (d1_req_valid),
    .req_ready (d1_req_ready),
    .req_we    (d1_req_we),
    .req_addr  (d1_req_addr),
    .req_wdata (d1_req_wdata),
    .req_be    (d1_req_be),
    .rsp_valid (d1_rsp_valid),
    .rsp_ready (d1_rsp_ready),
    .rsp_rdata (d1_rsp_rdata),
    .rsp_err   (d1_rsp_err)
  );

  // One transaction on the main DUT with rsp_ready held high. lat is the number of edges
  // after the accepting edge until rsp_valid is seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] rdata, output logic err,
                      output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (lat >= 32) begin
      n_vec++; n_err++;
      $display("FAIL xact_timeout: addr %h got no rsp_valid within %0d cycles", addr, lat);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'h0) begin n_err++;
      $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++;
      $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    n_vec++; if (d1_req_ready !== 1'b1 || d1_rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_d1: got ready %b valid %b expected 1 0", d1_req_ready, d1_rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, d, e, lat);
    n_vec++; if (lat !== Lat - 1) begin n_err++;
      $display("FAIL wr_latency: got %0d extra edges expected %0d", lat, Lat - 1); end
    n_vec++; if (d !== 32'h0) begin n_err++;
      $display("FAIL wr_rdata: got %h expected 0", d); end
    n_vec++; if (e !== 1'b0) begin n_err++;
      $display("FAIL wr_err: got %b expected 0", e); end
    xact(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++;
      $display("FAIL rd_rdata: got %h expected deadbeef", d); end
    n_vec++; if (lat !== Lat - 1) begin n_err++;
      $display("FAIL rd_latency: got %0d extra edges expected %0d", lat, Lat - 1); end
  endtask

  task automatic test_partial_write();
    logic [31:0] d; logic e; int lat;
    xact(1'b1, 32'h20, 32'h1122_3344, 4'hF, d, e, lat);
    xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, d, e, lat);
    xact(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h11BB_33DD) begin n_err++;
      $display("FAIL partial_be0101: got %h expected 11bb33dd", d); end
    xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, d, e, lat);
    n_vec++; if (lat !== Lat - 1) begin n_err++;
      $display("FAIL be0000_responds: got %0d extra edges expected %0d", lat, Lat - 1); end
    xact(1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h11BB_33DD) begin n_err++;
      $display("FAIL be0000_nochange: got %h expected 11bb33dd", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic e; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 32) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat !== Lat - 1) begin n_err++;
      $display("FAIL bp_latency: got %0d extra edges expected %0d", lat, Lat - 1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got valid %b rdata %h ready %b expected 1 deadbeef 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL bp_release: got ready %b valid %b expected 1 0", req_ready, rsp_valid);
    end
    xact(1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'hDEAD_BEEF) begin n_err++;
      $display("FAIL bp_ignored_write: got %h expected deadbeef", d); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int lat;
    xact(1'b1, 32'h40, 32'h1234_5678, 4'hF, d, e, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h5; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_wait_state: got ready %b valid %b expected 0 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_async: got ready %b valid %b rdata %h expected 1 0 0",
               req_ready, rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++;
        $display("FAIL rst_no_rsp%0d: got %b expected 0", i, rsp_valid); end
    end
    xact(1'b0, 32'h40, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h1234_5678) begin n_err++;
      $display("FAIL rst_write_dropped: got %h expected 12345678", d); end
  endtask

  task automatic test_range();
    logic [31:0] d; logic e; int lat;
    xact(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, d, e, lat);
    xact(1'b1, 32'h1000, 32'h7, 4'hF, d, e, lat);
`ifdef DMEM_ACCESS_CHECK_EN
    n_vec++; if (e !== 1'b1) begin n_err++;
      $display("FAIL oor_write_err: got %b expected 1", e); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'hCAFE_F00D) begin n_err++;
      $display("FAIL oor_write_dropped: got %h expected cafef00d", d); end
    xact(1'b0, 32'h1002, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h0 || e !== 1'b1) begin n_err++;
      $display("FAIL oor_read: got rdata %h err %b expected 0 1", d, e); end
    xact(1'b0, 32'h12, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h0 || e !== 1'b1) begin n_err++;
      $display("FAIL misaligned_read: got rdata %h err %b expected 0 1", d, e); end
`else
    n_vec++; if (e !== 1'b0) begin n_err++;
      $display("FAIL alias_write_err: got %b expected 0", e); end
    xact(1'b0, 32'h0, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h7) begin n_err++;
      $display("FAIL alias_word0: got %h expected 00000007", d); end
    xact(1'b0, 32'h1002, 32'h0, 4'h0, d, e, lat);
    n_vec++; if (d !== 32'h7 || e !== 1'b0) begin n_err++;
      $display("FAIL alias_read_lowbits: got rdata %h err %b expected 7 0", d, e); end
`endif
  endtask

  // LATENCY = 1 with req_valid held high: responses appear after every odd edge.
  task automatic run_b2b(input logic we);
    int got = 0;
    logic exp_v;
    logic [31:0] exp_d;
    d1_rsp_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      d1_req_valid = 1'b1;
      d1_req_we    = we;
      d1_req_addr  = 32'h100 + 32'(got * 4);
      d1_req_wdata = 32'hA000_0000 + 32'(got);
      d1_req_be    = 4'hF;
      @(posedge clk); #1;
      exp_v = (c % 2 == 1);
      n_vec++; if (d1_rsp_valid !== exp_v) begin n_err++;
        $display("FAIL b2b_valid we=%b edge%0d: got %b expected %b", we, c, d1_rsp_valid, exp_v);
      end
      if (exp_v) begin
        exp_d = we ? 32'h0 : 32'hA000_0000 + 32'(got);
        n_vec++; if (d1_rsp_rdata !== exp_d) begin n_err++;
          $display("FAIL b2b_rdata we=%b #%0d: got %h expected %h", we, got, d1_rsp_rdata, exp_d);
        end
        got++;
      end
    end
    @(negedge clk);
    d1_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_b2b(1'b1);
    run_b2b(1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure();
    test_reset_mid_wait();
    test_range();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
